dispatch_fifo_router: RTL and testbench
=======================================

# dispatch_fifo_router

Registered, flow-controlled successor to the combinational valid/id decoder in the MemorEDF datapath. It accepts one request per cycle (target id, payload, optional broadcast) through a valid/ready handshake and queues it into a per-output FIFO of configurable depth. Each output drains independently through its own valid/ready pair, so a stalled consumer back-pressures only requests aimed at it. Sits between the EDF scheduler and the per-port request queues.

## Interface
- OUTPUTS, 4: number of output channels, ≥2, need not be a power of two.
- INPUT_SIZE, 8: payload width in bits.
- DEPTH, 2: entries per output FIFO, power of two, ≥2.
- ID_W (localparam): $clog2(OUTPUTS).
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  request will be accepted this cycle.
- in_id  in  ID_W  target channel (ignored when in_broadcast=1).
- in_broadcast  in  1  deliver to all OUTPUTS channels.
- in_data  in  INPUT_SIZE  payload.
- out_valid  out  OUTPUTS  channel i has a head entry.
- out_ready  in  OUTPUTS  channel i consumer takes head.
- out_data  out  OUTPUTS*INPUT_SIZE  channel i head at bits [i*INPUT_SIZE +: INPUT_SIZE].
- bad_id  out  1  one-cycle pulse: a unicast with in_id ≥ OUTPUTS was accepted and discarded.
- occupancy  out  OUTPUTS*($clog2(DEPTH)+1)  per-channel entry count.

## Operation
- Accept = in_valid & in_ready. in_ready never depends on in_valid or out_ready.
- Unicast, in_id < OUTPUTS: in_ready = (count[in_id] < DEPTH); on accept push into FIFO in_id only.
- Unicast, in_id ≥ OUTPUTS: in_ready = 1; nothing stored; bad_id=1 the following cycle.
- Broadcast: in_ready = 1 only if every FIFO has count < DEPTH; on accept push into all FIFOs in the same cycle (all or none).
- Pop on channel i = out_valid[i] & out_ready[i]; advances read pointer.
- out_valid[i] = (count[i] != 0); out_data is the head entry, unspecified when out_valid low.
- Push and pop on same channel same cycle: count unchanged, both pointers advance. in_ready uses the pre-edge count: a full FIFO refuses a push even while popping (no bypass).
- Pointers are $clog2(DEPTH) bits and wrap naturally; count is $clog2(DEPTH)+1 bits, range 0..DEPTH.
- Per channel FIFO order is strict; broadcast entries interleave with unicasts in acceptance order.

## Timing
- Reset: all counts and pointers 0, out_valid=0, occupancy=0, bad_id=0, in_ready reflects empty FIFOs (1). Storage not reset.
- Reset asserted mid-operation: all queued entries are lost at that edge; a handshake in the same cycle is not stored.
- Latency: accepted at edge k → out_valid[i]=1 during cycle k+1 (one cycle, no combinational in→out path).
- Pop at edge k → next entry (if any) presented in cycle k+1; back-to-back pops sustain one entry/cycle.
- Throughput: one accepted request per cycle when target not full.
- occupancy and bad_id are registered, updated on the same edge as the push/pop.

## Structure
- Package dispatch_pkg: function for count width, typedef of a channel payload, packed-array helpers for out_data/occupancy slicing.
- Sub-module dispatch_channel_fifo (DEPTH, INPUT_SIZE): push, push_data, pop, head, valid, full, count; instantiated OUTPUTS times in a generate loop. Top holds only the decode, in_ready logic and bad_id register.

## Test plan
- After reset, OUTPUTS=4, DEPTH=2: in_id=2, data=0xA5 one cycle → out_valid=4'b0100 next cycle, out_data[2]=0xA5, occupancy[2]=1.
- Hold out_ready[1]=0, send three requests to id 1 → first two accepted, in_ready=0 on third; pulse out_ready[1] → third accepted the cycle after pop, order 1,2,3 preserved.
- Broadcast 0x3C with channel 3 full → in_ready=0, no channel written; drain one of channel 3 → accepted, all four out_valid high, each head 0x3C after its queued data.
- OUTPUTS=3: unicast in_id=3 → in_ready=1, bad_id pulses one cycle, all occupancy unchanged.
- Channel 0 at count 1, simultaneous push and pop every cycle for 10 cycles → count stays 1, data in order, wraps pointers cleanly.
- Fill all channels, assert reset one cycle with in_valid=1 → all out_valid=0, occupancy=0, in_ready=1 next cycle, no entry retained.

Source files
------------

// File: rtl/dispatch_fifo_router_pkg.sv
// -----------------------------------------------------------------------------
// dispatch_pkg
// Shared definitions for the dispatch FIFO router: the default channel payload
// type, the per-channel count width and lane-offset helpers used when slicing
// the flattened out_data / occupancy buses.
// Ports: none (package).
// -----------------------------------------------------------------------------
package dispatch_pkg;

    localparam int unsigned PAYLOAD_W = 8;

    typedef logic [PAYLOAD_W-1:0] payload_t;

    // Count must hold 0..depth inclusive, hence one bit more than the pointer.
    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // LSB of lane 'lane' inside a flattened bus of 'width'-bit lanes.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/dispatch_fifo_router_if.sv
// -----------------------------------------------------------------------------
// dispatch_fifo_router_if
// Bundles the request handshake and the per-channel output handshakes of the
// dispatch FIFO router.
//   in_valid/in_ready/in_id/in_broadcast/in_data : request side
//   out_valid/out_ready/out_data                  : per-channel drain side
//   bad_id                                        : discarded out-of-range unicast
//   occupancy                                     : per-channel entry count
// Modports: slave = router, master = producer/consumer environment.
// -----------------------------------------------------------------------------
interface dispatch_fifo_router_if
    import dispatch_pkg::*;
#(
    parameter int OUTPUTS    = 4,
    parameter int INPUT_SIZE = $bits(payload_t),
    parameter int DEPTH      = 2
);
    localparam int ID_W  = $clog2(OUTPUTS);
    localparam int CNT_W = count_w(DEPTH);

    logic                          in_valid;
    logic                          in_ready;
    logic [ID_W-1:0]               in_id;
    logic                          in_broadcast;
    logic [INPUT_SIZE-1:0]         in_data;
    logic [OUTPUTS-1:0]            out_valid;
    logic [OUTPUTS-1:0]            out_ready;
    logic [OUTPUTS*INPUT_SIZE-1:0] out_data;
    logic                          bad_id;
    logic [OUTPUTS*CNT_W-1:0]      occupancy;

    modport slave (
        input  in_valid, in_id, in_broadcast, in_data, out_ready,
        output in_ready, out_valid, out_data, bad_id, occupancy
    );

    modport master (
        output in_valid, in_id, in_broadcast, in_data, out_ready,
        input  in_ready, out_valid, out_data, bad_id, occupancy
    );

endinterface

// File: rtl/dispatch_fifo_router_channel_fifo.sv
// -----------------------------------------------------------------------------
// dispatch_channel_fifo
// One output channel queue of the dispatch router: DEPTH-entry circular buffer
// with free-running wrap pointers and an explicit entry count.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   push/push_data : write one entry (ignored when full)
//   pop            : consume head (ignored when empty)
//   head/valid     : head entry and non-empty flag
//   full/count     : full flag and entry count 0..DEPTH
// Storage is not reset; only pointers and count are.
// -----------------------------------------------------------------------------
module dispatch_channel_fifo
    import dispatch_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int INPUT_SIZE = $bits(payload_t)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        push,
    input  logic [INPUT_SIZE-1:0]       push_data,
    input  logic                        pop,
    output logic [INPUT_SIZE-1:0]       head,
    output logic                        valid,
    output logic                        full,
    output logic [count_w(DEPTH)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = count_w(DEPTH);

    logic [INPUT_SIZE-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  push_eff;
    logic                  pop_eff;

    assign valid    = (count != '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign head     = mem[rd_ptr];
    assign push_eff = push & ~full;
    assign pop_eff  = pop & valid;

    always_ff @(posedge clock) begin
        if (push_eff) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_eff, pop_eff})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dispatch_fifo_router.sv
// -----------------------------------------------------------------------------
// dispatch_fifo_router
// Accepts one request per cycle (unicast to in_id or broadcast to all channels)
// and queues it into per-channel FIFOs that drain independently.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : request handshake, per-channel out_valid/out_ready/out_data,
//                  bad_id pulse and per-channel occupancy
// in_ready depends only on in_id/in_broadcast and the registered FIFO counts,
// never on in_valid or out_ready; a full FIFO refuses even while popping.
// -----------------------------------------------------------------------------
module dispatch_fifo_router
    import dispatch_pkg::*;
#(
    parameter int OUTPUTS    = 4,
    parameter int INPUT_SIZE = $bits(payload_t),
    parameter int DEPTH      = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    dispatch_fifo_router_if.slave  bus
);
    localparam int ID_W   = $clog2(OUTPUTS);
    localparam int CNT_W  = count_w(DEPTH);
    localparam int ID_SPAN = 2 ** ID_W;

    logic [OUTPUTS-1:0]    full;
    logic [OUTPUTS-1:0]    push;
    logic [OUTPUTS-1:0]    pop;
    logic [ID_SPAN-1:0]    full_span;
    logic                  id_ok;
    logic                  target_full;
    logic                  accept;
    logic                  bad_id_q;

    // Widen the full vector to every encodable id so indexing by in_id stays in
    // range when OUTPUTS is not a power of two; unused ids read as not full.
    always_comb begin
        full_span = '0;
        for (int i = 0; i < OUTPUTS; i++) begin
            full_span[i] = full[i];
        end
    end

    assign id_ok       = (32'(bus.in_id) < 32'(OUTPUTS));
    assign target_full = full_span[bus.in_id];

    always_comb begin
        if (bus.in_broadcast) begin
            bus.in_ready = ~|full;
        end else if (id_ok) begin
            bus.in_ready = ~target_full;
        end else begin
            bus.in_ready = 1'b1;
        end
    end

    assign accept = bus.in_valid & bus.in_ready;

    genvar g;
    generate
        for (g = 0; g < OUTPUTS; g++) begin : g_chan
            logic [CNT_W-1:0] count;

            assign push[g] = accept &
                             (bus.in_broadcast | (id_ok & (bus.in_id == ID_W'(g))));
            assign pop[g]  = bus.out_valid[g] & bus.out_ready[g];

            dispatch_channel_fifo #(
                .DEPTH      (DEPTH),
                .INPUT_SIZE (INPUT_SIZE)
            ) u_fifo (
                .clock     (clock),
                .reset     (reset),
                .push      (push[g]),
                .push_data (bus.in_data),
                .pop       (pop[g]),
                .head      (bus.out_data[lane_lsb(g, INPUT_SIZE) +: INPUT_SIZE]),
                .valid     (bus.out_valid[g]),
                .full      (full[g]),
                .count     (count)
            );

            assign bus.occupancy[lane_lsb(g, CNT_W) +: CNT_W] = count;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            bad_id_q <= 1'b0;
        end else begin
            bad_id_q <= accept & ~bus.in_broadcast & ~id_ok;
        end
    end

    assign bus.bad_id = bad_id_q;

endmodule

// File: tb/tb_dispatch_fifo_router.sv
module tb_dispatch_fifo_router;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    dispatch_fifo_router_if #(.OUTPUTS(4), .INPUT_SIZE(8), .DEPTH(2)) bus4 ();
    dispatch_fifo_router_if #(.OUTPUTS(3), .INPUT_SIZE(8), .DEPTH(2)) bus3 ();

    dispatch_fifo_router #(.OUTPUTS(4), .INPUT_SIZE(8), .DEPTH(2)) u_dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (bus4)
    );

    dispatch_fifo_router #(.OUTPUTS(3), .INPUT_SIZE(8), .DEPTH(2)) u_dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (bus3)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic drive4(input logic v, input logic b, input logic [1:0] id,
                          input logic [7:0] d);
        bus4.in_valid     = v;
        bus4.in_broadcast = b;
        bus4.in_id        = id;
        bus4.in_data      = d;
    endtask

    task automatic drive3(input logic v, input logic b, input logic [1:0] id,
                          input logic [7:0] d);
        bus3.in_valid     = v;
        bus3.in_broadcast = b;
        bus3.in_id        = id;
        bus3.in_data      = d;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        drive4(1'b0, 1'b0, 2'd0, 8'h00);
        drive3(1'b0, 1'b0, 2'd0, 8'h00);
        bus4.out_ready = 4'hF;
        bus3.out_ready = 3'b000;
        step();
        step();
        reset = 1'b0;

        // Reset state
        settle();
        check_val("rst_out_valid", 64'(bus4.out_valid), 64'h0);
        check_val("rst_occupancy", 64'(bus4.occupancy), 64'h0);
        check_val("rst_in_ready", 64'(bus4.in_ready), 64'h1);
        check_val("rst_bad_id", 64'(bus4.bad_id), 64'h0);
        check_val("rst3_out_valid", 64'(bus3.out_valid), 64'h0);
        step();

        // Single unicast to channel 2, one-cycle latency
        drive4(1'b1, 1'b0, 2'd2, 8'hA5);
        settle();
        check_val("t1_in_ready", 64'(bus4.in_ready), 64'h1);
        check_val("t1_no_comb_path", 64'(bus4.out_valid), 64'h0);
        step();
        drive4(1'b0, 1'b0, 2'd0, 8'h00);
        settle();
        check_val("t1_out_valid", 64'(bus4.out_valid), 64'h4);
        check_val("t1_out_data2", 64'(bus4.out_data[23:16]), 64'hA5);
        check_val("t1_occupancy", 64'(bus4.occupancy), 64'h10);
        step();
        settle();
        check_val("t1_drained", 64'(bus4.out_valid), 64'h0);
        step();

        // Back-pressure on channel 1, no bypass on a full FIFO
        bus4.out_ready = 4'b1101;
        drive4(1'b1, 1'b0, 2'd1, 8'h11);
        settle();
        check_val("t2_rdy_a", 64'(bus4.in_ready), 64'h1);
        step();
        drive4(1'b1, 1'b0, 2'd1, 8'h22);
        settle();
        check_val("t2_rdy_b", 64'(bus4.in_ready), 64'h1);
        step();
        drive4(1'b1, 1'b0, 2'd1, 8'h33);
        settle();
        check_val("t2_rdy_full", 64'(bus4.in_ready), 64'h0);
        check_val("t2_occ_full", 64'(bus4.occupancy), 64'h08);
        check_val("t2_head_a", 64'(bus4.out_data[15:8]), 64'h11);
        step();
        bus4.out_ready = 4'b1111;
        settle();
        check_val("t2_no_bypass", 64'(bus4.in_ready), 64'h0);
        step();
        bus4.out_ready = 4'b1101;
        settle();
        check_val("t2_rdy_after_pop", 64'(bus4.in_ready), 64'h1);
        check_val("t2_head_b", 64'(bus4.out_data[15:8]), 64'h22);
        step();
        drive4(1'b0, 1'b0, 2'd0, 8'h00);
        settle();
        check_val("t2_head_b_hold", 64'(bus4.out_data[15:8]), 64'h22);
        check_val("t2_occ_refill", 64'(bus4.occupancy), 64'h08);
        bus4.out_ready = 4'b1111;
        step();
        settle();
        check_val("t2_head_c", 64'(bus4.out_data[15:8]), 64'h33);
        check_val("t2_occ_one", 64'(bus4.occupancy), 64'h04);
        step();
        settle();
        check_val("t2_drained", 64'(bus4.out_valid), 64'h0);
        step();

        // Broadcast blocked by full channel 3, then admitted after one drain
        bus4.out_ready = 4'b0110;
        drive4(1'b1, 1'b0, 2'd0, 8'h01);
        settle();
        step();
        drive4(1'b1, 1'b0, 2'd3, 8'h31);
        settle();
        step();
        drive4(1'b1, 1'b0, 2'd3, 8'h32);
        settle();
        step();
        drive4(1'b1, 1'b1, 2'd0, 8'h3C);
        settle();
        check_val("t3_bc_blocked", 64'(bus4.in_ready), 64'h0);
        check_val("t3_occ_pre", 64'(bus4.occupancy), 64'h81);
        step();
        bus4.out_ready = 4'b1110;
        settle();
        check_val("t3_none_written", 64'(bus4.occupancy), 64'h81);
        check_val("t3_valid_pre", 64'(bus4.out_valid), 64'h9);
        check_val("t3_bc_still_blocked", 64'(bus4.in_ready), 64'h0);
        step();
        bus4.out_ready = 4'b0000;
        settle();
        check_val("t3_bc_ready", 64'(bus4.in_ready), 64'h1);
        step();
        drive4(1'b0, 1'b0, 2'd0, 8'h00);
        settle();
        check_val("t3_all_valid", 64'(bus4.out_valid), 64'hF);
        check_val("t3_occ_post", 64'(bus4.occupancy), 64'h96);
        check_val("t3_heads", 64'(bus4.out_data), 64'h323C3C01);
        bus4.out_ready = 4'b1111;
        step();
        settle();
        check_val("t3_valid_second", 64'(bus4.out_valid), 64'h9);
        check_val("t3_head0_bc", 64'(bus4.out_data[7:0]), 64'h3C);
        check_val("t3_head3_bc", 64'(bus4.out_data[31:24]), 64'h3C);
        step();
        settle();
        check_val("t3_drained", 64'(bus4.out_valid), 64'h0);
        step();

        // OUTPUTS=3: out-of-range unicast is accepted and discarded
        drive3(1'b1, 1'b0, 2'd1, 8'h55);
        settle();
        step();
        drive3(1'b1, 1'b0, 2'd3, 8'h77);
        settle();
        check_val("t4_rdy_bad", 64'(bus3.in_ready), 64'h1);
        check_val("t4_bad_pre", 64'(bus3.bad_id), 64'h0);
        step();
        drive3(1'b0, 1'b0, 2'd0, 8'h00);
        settle();
        check_val("t4_bad_pulse", 64'(bus3.bad_id), 64'h1);
        check_val("t4_occ", 64'(bus3.occupancy), 64'h04);
        check_val("t4_valid", 64'(bus3.out_valid), 64'h2);
        step();
        settle();
        check_val("t4_bad_clear", 64'(bus3.bad_id), 64'h0);
        check_val("t4_occ_hold", 64'(bus3.occupancy), 64'h04);
        step();

        // Channel 0 held at count 1 with simultaneous push and pop
        bus4.out_ready = 4'b0000;
        drive4(1'b1, 1'b0, 2'd0, 8'h40);
        settle();
        step();
        bus4.out_ready = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            drive4(1'b1, 1'b0, 2'd0, 8'(8'h40 + k));
            settle();
            check_val($sformatf("t5_head_%0d", k), 64'(bus4.out_data[7:0]),
                      64'(8'h40 + k - 1));
            check_val($sformatf("t5_occ_%0d", k), 64'(bus4.occupancy), 64'h01);
            check_val($sformatf("t5_rdy_%0d", k), 64'(bus4.in_ready), 64'h1);
            step();
        end
        drive4(1'b0, 1'b0, 2'd0, 8'h00);
        settle();
        check_val("t5_last_head", 64'(bus4.out_data[7:0]), 64'h4A);
        check_val("t5_last_occ", 64'(bus4.occupancy), 64'h01);
        step();
        settle();
        check_val("t5_drained", 64'(bus4.out_valid), 64'h0);
        step();

        // Fill everything, then reset with a live handshake
        bus4.out_ready = 4'b0000;
        drive4(1'b1, 1'b1, 2'd0, 8'hB1);
        settle();
        step();
        drive4(1'b1, 1'b1, 2'd0, 8'hB2);
        settle();
        step();
        drive4(1'b1, 1'b1, 2'd0, 8'hB3);
        settle();
        check_val("t6_full_block", 64'(bus4.in_ready), 64'h0);
        check_val("t6_occ_full", 64'(bus4.occupancy), 64'hAA);
        drive4(1'b0, 1'b0, 2'd0, 8'h00);
        bus4.out_ready = 4'b0001;
        step();
        bus4.out_ready = 4'b0000;
        drive4(1'b1, 1'b0, 2'd0, 8'hEE);
        reset = 1'b1;
        settle();
        check_val("t6_rdy_in_reset", 64'(bus4.in_ready), 64'h1);
        step();
        reset = 1'b0;
        drive4(1'b0, 1'b0, 2'd0, 8'h00);
        settle();
        check_val("t6_valid", 64'(bus4.out_valid), 64'h0);
        check_val("t6_occ", 64'(bus4.occupancy), 64'h0);
        check_val("t6_rdy", 64'(bus4.in_ready), 64'h1);
        check_val("t6_bad", 64'(bus4.bad_id), 64'h0);
        check_val("t6_occ3", 64'(bus3.occupancy), 64'h0);
        step();
        settle();
        check_val("t6_nothing_kept", 64'(bus4.out_valid), 64'h0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
